// File: rtl/mux8_rr_arbiter_if.sv
// Purpose: handshake/data bundle between 8 requesters and the shared 8:1 mux arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req until granted; the arbiter paces them via gnt/valid.
interface mux8_rr_arbiter_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] d_in;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       valid;
   logic       y;

   // Requester side: drives requests, release and mux data; observes grant.
   modport master (
      output req, done, d_in,
      input  sel, gnt, valid, y
   );

   // Arbiter side.
   modport slave (
      input  req, done, d_in,
      output sel, gnt, valid, y
   );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Purpose: round-robin arbiter sequencing one shared 8:1 single-bit mux among 8 requesters.
// Latency: 1 cycle from req to grant; back-to-back handover on release with no idle cycle.
// Backpressure: an owner holds at most MAX_HOLD cycles while others wait; a sole requester may hold forever.
module mux8_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   mux8_rr_arbiter_if.slave    bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [7:0]       gnt_q, gnt_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] hold_q, hold_d;

   logic             others;
   logic             drop_owner;
   logic             rel;
   logic [7:0]       cand;
   logic [2:0]       start;
   logic [3:0]       pick;

   // First set bit of cand scanning start, start+1, ... modulo 8; {found, index}.
   function automatic logic [3:0] rr_pick(input logic [7:0] c, input logic [2:0] s);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0;
      // Scan from the far end so the nearest hit to s is the last one written.
      for (int k = 7; k >= 0; k--) begin
         idx = s + 3'(k);
         if (c[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // Next-state: priority search, release detection and hold counting.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      valid_d    = valid_q;
      hold_d     = hold_q;

      others     = |(bus.req & ~gnt_q);
      // Owner leaving voluntarily (done or dropped request) is excluded from the re-search;
      // a timed-out owner stays eligible but is scanned last because the search starts after it.
      drop_owner = bus.done | ~bus.req[sel_q];
      rel        = drop_owner | ((hold_q == CNT_W'(MAX_HOLD)) & others);

      cand  = bus.req;
      start = ptr_q;
      if (state_q == GRANT) begin
         start = sel_q + 3'd1;
         if (drop_owner) begin
            cand = bus.req & ~gnt_q;
         end
      end
      pick = rr_pick(cand, start);

      case (state_q)
         IDLE: begin
            if (pick[3]) begin
               state_d = GRANT;
               sel_d   = pick[2:0];
               gnt_d   = 8'h01 << pick[2:0];
               valid_d = 1'b1;
               hold_d  = CNT_W'(1);
            end
         end
         GRANT: begin
            if (!rel) begin
               if (hold_q != CNT_W'(MAX_HOLD)) begin
                  hold_d = hold_q + CNT_W'(1);
               end
            end else begin
               ptr_d = start;
               if (pick[3]) begin
                  sel_d  = pick[2:0];
                  gnt_d  = 8'h01 << pick[2:0];
                  hold_d = CNT_W'(1);
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  gnt_d   = 8'h00;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            gnt_d   = 8'h00;
         end
      endcase
   end

   // State and registered outputs; async reset clears grant immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         ptr_q   <= 3'd0;
         gnt_q   <= 8'h00;
         valid_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.sel   = sel_q;
   assign bus.gnt   = gnt_q;
   assign bus.valid = valid_q;
   // Mux output gated by ownership so idle cycles present 0.
   assign bus.y     = valid_q ? bus.d_in[sel_q] : 1'b0;

endmodule
